// File: rtl/a2d_spi_resp.sv
// SPI mode-0 responder emulating an eight-channel 12-bit A2D converter.
// A 16-bit command frame selects a channel; the next frame returns {4'h0, sample}.
module a2d_spi_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [95:0] ch_data,
    output logic [2:0]  chnnl_sel,
    output logic        cnv_vld,
    output logic        frm_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef enum logic {
        PH_CMD  = 1'b0,
        PH_DATA = 1'b1
    } phase_t;

    // Synchronizer chains: [0],[1] are the sync stages, [2] is edge history
    logic [2:0]  ss_q, ss_d;
    logic [2:0]  sclk_q, sclk_d;
    logic [1:0]  mosi_q, mosi_d;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] rx_shft_q, rx_shft_d;
    logic [15:0] tx_shft_q, tx_shft_d;
    logic [11:0] samp_q, samp_d;
    logic [2:0]  chnnl_sel_q, chnnl_sel_d;
    logic        cnv_vld_q, cnv_vld_d;
    logic        frm_err_q, frm_err_d;

    logic        sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic        mosi_synced;
    logic [15:0] rx_next;
    logic [4:0]  cnt_next;
    logic [11:0] ch_arr [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch_slice
            assign ch_arr[gi] = ch_data[12*gi +: 12];
        end
    endgenerate

    always_comb begin
        ss_d   = {ss_q[1:0], SS_n};
        sclk_d = {sclk_q[1:0], SCLK};
        mosi_d = {mosi_q[0], MOSI};
    end

    assign sclk_rise   =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall   = ~sclk_q[1] &  sclk_q[2];
    assign ss_fall     = ~ss_q[1]   &  ss_q[2];
    assign ss_rise     =  ss_q[1]   & ~ss_q[2];
    assign mosi_synced =  mosi_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q   <= 3'b111;
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
        end else begin
            ss_q   <= ss_d;
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = SHIFT;
            SHIFT:   if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        MISO = 1'b0;
        if (state_q == SHIFT) begin
            MISO = tx_shft_q[15];
        end
    end

    // A coincident sclk_rise is folded in before the frame-end count is judged
    always_comb begin
        rx_next  = rx_shft_q;
        cnt_next = bit_cnt_q;
        if ((state_q == SHIFT) && sclk_rise) begin
            rx_next  = {rx_shft_q[14:0], mosi_synced};
            cnt_next = (bit_cnt_q == 5'd17) ? 5'd17 : bit_cnt_q + 5'd1;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shft_d   = rx_shft_q;
        tx_shft_d   = tx_shft_q;
        samp_d      = samp_q;
        chnnl_sel_d = chnnl_sel_q;
        cnv_vld_d   = 1'b0;
        frm_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    bit_cnt_d = 5'd0;
                    tx_shft_d = (phase_q == PH_CMD) ? 16'h0000 : {4'h0, samp_q};
                end
            end
            SHIFT: begin
                rx_shft_d = rx_next;
                bit_cnt_d = cnt_next;
                // No shift after the 16th bit: the last data bit stays on MISO
                if (sclk_fall && (bit_cnt_q != 5'd0) && (bit_cnt_q < 5'd16)) begin
                    tx_shft_d = {tx_shft_q[14:0], 1'b0};
                end
                if (ss_rise) begin
                    if (cnt_next == 5'd16) begin
                        if (phase_q == PH_CMD) begin
                            chnnl_sel_d = rx_next[13:11];
                            samp_d      = ch_arr[rx_next[13:11]];
                            phase_d     = PH_DATA;
                        end else begin
                            cnv_vld_d = 1'b1;
                            phase_d   = PH_CMD;
                        end
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= PH_CMD;
            bit_cnt_q   <= 5'd0;
            rx_shft_q   <= 16'h0000;
            tx_shft_q   <= 16'h0000;
            samp_q      <= 12'h000;
            chnnl_sel_q <= 3'd0;
            cnv_vld_q   <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shft_q   <= rx_shft_d;
            tx_shft_q   <= tx_shft_d;
            samp_q      <= samp_d;
            chnnl_sel_q <= chnnl_sel_d;
            cnv_vld_q   <= cnv_vld_d;
            frm_err_q   <= frm_err_d;
        end
    end

    assign chnnl_sel = chnnl_sel_q;
    assign cnv_vld   = cnv_vld_q;
    assign frm_err   = frm_err_q;

endmodule
